// File: rtl/rv_mem_arb.sv
// rv_mem_arb -- core/debug arbiter in front of one memory port.
// One access in flight, round-robin on ties, dbg_halt fences the core.
module rv_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          dbg_halt,
    output logic          halt_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          we_q;
    logic          last_q;
    logic [1:0]    cnt_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic c_elig;
    logic d_elig;
    logic any_elig;
    logic pick_d;
    logic wait_done;

    // owner_q / last_q: 0 = core, 1 = debug
    assign c_elig    = c_req & ~dbg_halt;
    assign d_elig    = d_req;
    assign any_elig  = c_elig | d_elig;
    assign pick_d    = d_elig & (~c_elig | ~last_q);
    assign wait_done = (state_q == WAIT) && (cnt_q == CNT_LAST);

    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch owner and direction when leaving IDLE; remember who won
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
        end else if (state_q == IDLE && any_elig) begin
            owner_q <= pick_d;
            we_q    <= pick_d ? d_we : c_we;
            last_q  <= pick_d;
        end
    end

    // Latency counter, only advances inside WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else if (state_q == WAIT && !wait_done) begin
            cnt_q <= cnt_q + 2'd1;
        end else begin
            cnt_q <= 2'd0;
        end
    end

    // Capture read data into the owner's register on the last WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (wait_done) begin
            if (owner_q) begin
                d_rdata_q <= mem_rdata;
            end else begin
                c_rdata_q <= mem_rdata;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_elig) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : WAIT;
            WAIT:    if (wait_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; the memory bus is only driven during ACCESS
    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        halt_ack  = dbg_halt & ~((state_q != IDLE) & ~owner_q);
        unique case (state_q)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = owner_q ? d_we : c_we;
                mem_addr  = owner_q ? d_addr : c_addr;
                mem_wdata = owner_q ? d_wdata : c_wdata;
                c_gnt     = ~owner_q;
                d_gnt     = owner_q;
            end
            RESP: begin
                c_rvalid = ~owner_q;
                d_rvalid = owner_q;
            end
            IDLE, WAIT: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb -- vector table, corner sequences and a random run
// against a transaction-level timing model of the arbiter.
module tb_rv_mem_arb;

    localparam int LAT = 1;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        dbg_halt, halt_ack, mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        x_c_req, x_c_we, x_c_gnt, x_c_rvalid;
    logic [31:0] x_c_addr, x_c_wdata, x_c_rdata;
    logic        x_d_req, x_d_we, x_d_gnt, x_d_rvalid;
    logic [31:0] x_d_addr, x_d_wdata, x_d_rdata;
    logic        x_halt, x_halt_ack, x_mem_en, x_mem_we, x_busy;
    logic [31:0] x_mem_addr, x_mem_wdata, x_mem_rdata;

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(LAT)) u1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dbg_halt(dbg_halt), .halt_ack(halt_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .c_req(x_c_req), .c_we(x_c_we), .c_addr(x_c_addr), .c_wdata(x_c_wdata),
        .c_gnt(x_c_gnt), .c_rvalid(x_c_rvalid), .c_rdata(x_c_rdata),
        .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_gnt(x_d_gnt), .d_rvalid(x_d_rvalid), .d_rdata(x_d_rdata),
        .dbg_halt(x_halt), .halt_ack(x_halt_ack),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr),
        .mem_wdata(x_mem_wdata), .mem_rdata(x_mem_rdata), .busy(x_busy)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        if (a == 32'h80) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memories: read data appears exactly N cycles after the mem_en cycle
    logic [31:0] p1;
    logic [31:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= (mem_en && !mem_we) ? mem_fn(mem_addr) : JUNK;
        p3[0] <= (x_mem_en && !x_mem_we) ? mem_fn(x_mem_addr) : JUNK;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata   = p1;
    assign x_mem_rdata = p3[2];

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic h;
    } in_t;

    typedef struct {
        logic cg, dg, cv, dv, en, we;
        logic [31:0] addr, wdata;
        logic bsy, hack;
        logic [31:0] crd, drd;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic in_t mk_in(
        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic h);
        in_t r;
        r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.dr = dr; r.dw = dw; r.da = da; r.dd = dd; r.h = h;
        return r;
    endfunction

    function automatic exp_t mk_exp(
        input logic cg, input logic dg, input logic cv, input logic dv,
        input logic en, input logic we, input logic [31:0] addr,
        input logic [31:0] wdata, input logic bsy, input logic hack,
        input logic [31:0] crd, input logic [31:0] drd);
        exp_t r;
        r.cg = cg; r.dg = dg; r.cv = cv; r.dv = dv; r.en = en; r.we = we;
        r.addr = addr; r.wdata = wdata; r.bsy = bsy; r.hack = hack;
        r.crd = crd; r.drd = drd;
        return r;
    endfunction

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    task automatic chkw(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic chk_all(input string t, input exp_t e);
        chk1({t, ".c_gnt"}, c_gnt, e.cg);
        chk1({t, ".d_gnt"}, d_gnt, e.dg);
        chk1({t, ".c_rvalid"}, c_rvalid, e.cv);
        chk1({t, ".d_rvalid"}, d_rvalid, e.dv);
        chk1({t, ".mem_en"}, mem_en, e.en);
        chk1({t, ".mem_we"}, mem_we, e.we);
        chkw({t, ".mem_addr"}, mem_addr, e.addr);
        chkw({t, ".mem_wdata"}, mem_wdata, e.wdata);
        chk1({t, ".busy"}, busy, e.bsy);
        chk1({t, ".halt_ack"}, halt_ack, e.hack);
        chkw({t, ".c_rdata"}, c_rdata, e.crd);
        chkw({t, ".d_rdata"}, d_rdata, e.drd);
    endtask

    task automatic drive(input in_t i);
        c_req = i.cr; c_we = i.cw; c_addr = i.ca; c_wdata = i.cd;
        d_req = i.dr; d_we = i.dw; d_addr = i.da; d_wdata = i.dd;
        dbg_halt = i.h;
    endtask

    task automatic clear_inputs();
        drive(mk_in(N, N, 0, 0, N, N, 0, 0, N));
        x_c_req = N; x_c_we = N; x_c_addr = '0; x_c_wdata = '0;
        x_d_req = N; x_d_we = N; x_d_addr = '0; x_d_wdata = '0;
        x_halt = N;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = N;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = Y;
        tick();
    endtask

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        in_t  ww, z, rd40, rd44, hz;
        exp_t ez;
        logic [31:0] be, r44;
        be   = 32'hDEAD_BEEF;
        r44  = mem_fn(32'h44);
        ww   = mk_in(Y, Y, 32'h100, 32'h11, Y, Y, 32'h200, 32'h22, N);
        z    = mk_in(N, N, 0, 0, N, N, 0, 0, N);
        rd40 = mk_in(Y, N, 32'h40, 0, N, N, 0, 0, N);
        rd44 = mk_in(Y, N, 32'h44, 0, N, N, 0, 0, N);
        hz   = mk_in(N, N, 0, 0, N, N, 0, 0, Y);
        ez   = mk_exp(N, N, N, N, N, N, 0, 0, N, N, 0, 0);
        // both ports write every cycle: C, D, C alternate
        add(ww, ez);
        add(ww, mk_exp(Y, N, N, N, Y, Y, 32'h100, 32'h11, Y, N, 0, 0));
        add(ww, ez);
        add(ww, mk_exp(N, Y, N, N, Y, Y, 32'h200, 32'h22, Y, N, 0, 0));
        add(ww, ez);
        add(ww, mk_exp(Y, N, N, N, Y, Y, 32'h100, 32'h11, Y, N, 0, 0));
        add(z, ez);
        // core read of 0x40
        add(rd40, ez);
        add(rd40, mk_exp(Y, N, N, N, Y, N, 32'h40, 0, Y, N, 0, 0));
        add(z, mk_exp(N, N, N, N, N, N, 0, 0, Y, N, 0, 0));
        add(z, mk_exp(N, N, Y, N, N, N, 0, 0, Y, N, be, 0));
        add(z, mk_exp(N, N, N, N, N, N, 0, 0, N, N, be, 0));
        // halt while idle blocks the core, release lets it through
        add(hz, mk_exp(N, N, N, N, N, N, 0, 0, N, Y, be, 0));
        rd44.h = Y;
        add(rd44, mk_exp(N, N, N, N, N, N, 0, 0, N, Y, be, 0));
        add(rd44, mk_exp(N, N, N, N, N, N, 0, 0, N, Y, be, 0));
        rd44.h = N;
        add(rd44, ez);
        tbl[$].e.crd = be;
        add(rd44, mk_exp(Y, N, N, N, Y, N, 32'h44, 0, Y, N, be, 0));
        add(z, mk_exp(N, N, N, N, N, N, 0, 0, Y, N, be, 0));
        add(z, mk_exp(N, N, Y, N, N, N, 0, 0, Y, N, r44, 0));
        add(z, mk_exp(N, N, N, N, N, N, 0, 0, N, N, r44, 0));
    endtask

    // Transaction-level model state for the random run
    int          m_g, m_fr;
    logic        m_own, m_last, m_we;
    logic [31:0] m_addr, m_crd, m_drd;
    logic        cg_seen, dg_seen;

    initial begin
        exp_t e;
        rst_n = N;
        clear_inputs();
        #2;
        chk_all("reset", mk_exp(N, N, N, N, N, N, 0, 0, N, N, 0, 0));
        do_reset();

        // MEM_LAT=3 debug read: rvalid five cycles after the request
        x_d_req = Y; x_d_we = N; x_d_addr = 32'h80;
        mid(); chk1("lat3.idle_gnt", x_d_gnt, N);
        tick(); mid();
        chk1("lat3.gnt", x_d_gnt, Y);
        chkw("lat3.addr", x_mem_addr, 32'h80);
        tick(); x_d_req = N;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk1("lat3.wait_rvalid", x_d_rvalid, N);
            chk1("lat3.wait_busy", x_busy, Y);
            tick();
        end
        mid();
        chk1("lat3.rvalid", x_d_rvalid, Y);
        chkw("lat3.d_rdata", x_d_rdata, 32'h1234_5678);
        chkw("lat3.c_rdata", x_c_rdata, 32'h0);
        tick(); mid();
        chk1("lat3.after", x_d_rvalid, N);
        chk1("lat3.idle", x_busy, N);
        tick();

        build_table();
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].i);
            mid();
            chk_all($sformatf("vec%0d", k), tbl[k].e);
            tick();
        end
        clear_inputs();

        // halt raised mid core read with another core request pending
        c_req = Y; c_we = N; c_addr = 32'h48;
        mid(); chk1("halt.idle", busy, N);
        tick(); mid();
        chk1("halt.gnt", c_gnt, Y);
        chkw("halt.addr", mem_addr, 32'h48);
        tick(); c_addr = 32'h4C; dbg_halt = Y;
        mid();
        chk1("halt.wait_ack", halt_ack, N);
        chk1("halt.wait_busy", busy, Y);
        tick(); mid();
        chk1("halt.rvalid", c_rvalid, Y);
        chk1("halt.resp_ack", halt_ack, N);
        chkw("halt.rdata", c_rdata, mem_fn(32'h48));
        tick(); mid();
        chk1("halt.ack", halt_ack, Y);
        chk1("halt.no_gnt", c_gnt, N);
        for (int k = 0; k < 3; k++) begin
            tick(); mid();
            chk1("halt.hold_gnt", c_gnt, N);
            chk1("halt.hold_en", mem_en, N);
            chk1("halt.hold_ack", halt_ack, Y);
        end
        tick(); d_req = Y; d_we = Y; d_addr = 32'h300; d_wdata = 32'h33;
        mid(); chk1("halt.d_idle", c_gnt, N);
        tick(); mid();
        chk1("halt.d_gnt", d_gnt, Y);
        chk1("halt.d_cgnt", c_gnt, N);
        chkw("halt.d_addr", mem_addr, 32'h300);
        chk1("halt.d_we", mem_we, Y);
        chk1("halt.d_ack", halt_ack, Y);
        tick(); d_req = N; dbg_halt = N;
        mid();
        chk1("halt.rel_gnt", c_gnt, N);
        chk1("halt.rel_ack", halt_ack, N);
        tick(); mid();
        chk1("halt.c_gnt", c_gnt, Y);
        chkw("halt.c_addr", mem_addr, 32'h4C);
        tick(); c_req = N;
        mid(); chk1("halt.c_wait", busy, Y);
        tick(); mid();
        chk1("halt.c_rvalid", c_rvalid, Y);
        chkw("halt.c_rdata", c_rdata, mem_fn(32'h4C));
        tick();

        // core request withdrawn while a debug write is on the bus
        c_req = Y; c_we = N; c_addr = 32'h50;
        d_req = Y; d_we = Y; d_addr = 32'h304; d_wdata = 32'h44;
        mid(); chk1("drop.idle", busy, N);
        tick(); c_req = N;
        mid();
        chk1("drop.d_gnt", d_gnt, Y);
        chk1("drop.c_gnt", c_gnt, N);
        chkw("drop.addr", mem_addr, 32'h304);
        for (int k = 0; k < 2; k++) begin
            tick(); d_req = N;
            mid();
            chk1("drop.after_gnt", c_gnt, N);
            chk1("drop.after_en", mem_en, N);
        end
        tick();

        // reset pulse during WAIT
        c_req = Y; c_we = N; c_addr = 32'h60;
        mid(); tick(); mid();
        chk1("rst.gnt", c_gnt, Y);
        tick(); c_req = N;
        mid(); chk1("rst.wait", busy, Y);
        #1 rst_n = N;
        #1;
        chk1("rst.busy", busy, N);
        chk1("rst.rvalid", c_rvalid, N);
        chkw("rst.c_rdata", c_rdata, 32'h0);
        tick(); mid();
        chk1("rst.no_rvalid", c_rvalid, N);
        chkw("rst.rdata_held", c_rdata, 32'h0);
        rst_n = Y;
        tick(); c_req = Y; c_addr = 32'h40;
        mid();
        chk1("rst.first_gnt", c_gnt, N);
        chk1("rst.first_rv", c_rvalid, N);
        tick(); mid();
        chk1("rst.new_gnt", c_gnt, Y);
        chkw("rst.new_addr", mem_addr, 32'h40);
        tick(); c_req = N;
        mid(); tick(); mid();
        chk1("rst.new_rvalid", c_rvalid, Y);
        chkw("rst.new_rdata", c_rdata, 32'hDEAD_BEEF);
        tick();

        // random traffic against the timing model
        do_reset();
        m_g = -100; m_fr = 0; m_own = N; m_last = Y; m_we = N;
        m_addr = '0; m_crd = '0; m_drd = '0;
        cg_seen = N; dg_seen = N;
        for (int t = 0; t < 1500; t++) begin
            if (cg_seen) c_req = N;
            if (dg_seen) d_req = N;
            if (!c_req && $urandom_range(0, 2) == 0) begin
                c_req = Y;
                c_we = 1'($urandom_range(0, 1));
                c_addr = 32'($urandom_range(0, 63)) << 2;
                c_wdata = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = Y;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) dbg_halt = ~dbg_halt;

            e = mk_exp(N, N, N, N, N, N, 0, 0, N, N, 0, 0);
            if (t == m_g) begin
                e.cg = ~m_own;
                e.dg = m_own;
                e.en = Y;
                e.we = m_own ? d_we : c_we;
                e.addr = m_own ? d_addr : c_addr;
                e.wdata = m_own ? d_wdata : c_wdata;
            end
            if (!m_we && t == m_g + 1 + LAT) begin
                if (m_own) begin
                    e.dv = Y;
                    m_drd = mem_fn(m_addr);
                end else begin
                    e.cv = Y;
                    m_crd = mem_fn(m_addr);
                end
            end
            e.bsy = (t >= m_g) && (t < m_fr);
            e.hack = dbg_halt && !(e.bsy && !m_own);
            e.crd = m_crd;
            e.drd = m_drd;
            if (t >= m_fr && ((c_req && !dbg_halt) || d_req)) begin
                if (c_req && !dbg_halt && d_req) m_own = ~m_last;
                else m_own = d_req && !(c_req && !dbg_halt);
                m_last = m_own;
                m_we = m_own ? d_we : c_we;
                m_addr = m_own ? d_addr : c_addr;
                m_g = t + 1;
                m_fr = m_we ? t + 2 : t + 3 + LAT;
            end

            mid();
            chk_all("rnd", e);
            cg_seen = c_gnt;
            dg_seen = d_gnt;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
